te_radio_enable_seq: RTL

//  Timing-engine stage S3: turns an asynchronous radio-enable request into the

---
 rtl/te_radio_enable_seq_pkg.sv | 14 +
 rtl/te_radio_enable_seq_if.sv | 12 +
 rtl/te_radio_enable_seq_sync.sv | 15 +
 rtl/te_radio_enable_seq.sv | 77 +++++++
 4 files changed

// File: rtl/te_radio_enable_seq_pkg.sv
// te_radio_enable_seq_pkg: shared state type, default timings and counter sizing for the radio-enable sequencer
package te_radio_enable_seq_pkg;
    typedef enum logic [1:0] {TE_RE_IDLE, TE_RE_WARMUP, TE_RE_ON, TE_RE_COOLDOWN} te_re_state_e;
    localparam int TE_SYNC_STAGES  = 2;
    localparam int TE_WARMUP_CYC   = 16;
    localparam int TE_MIN_ON_CYC   = 8;
    localparam int TE_COOLDOWN_CYC = 4;
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/te_radio_enable_seq_if.sv
// te_radio_enable_seq_if: request/isolate inputs and sequenced enable outputs of the sequencer
//   radio_req_async   raw request (async), isolateM1M2 force-off
//   radioEnableSynced sequenced enable, radio_busy not idle, warmup_done warm-up completion pulse
interface te_radio_enable_seq_if;
    logic radio_req_async;
    logic isolateM1M2;
    logic radioEnableSynced;
    logic radio_busy;
    logic warmup_done;
    modport master (output radio_req_async, isolateM1M2, input radioEnableSynced, radio_busy, warmup_done);
    modport slave  (input radio_req_async, isolateM1M2, output radioEnableSynced, radio_busy, warmup_done);
endinterface

// File: rtl/te_radio_enable_seq_sync.sv
// te_sync_ff: 1-bit multi-flop synchroniser cleared by synchronous active-low reset
//   ck clock, srst_n reset, i_d async input, o_q synchronised output
module te_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic ck,
    input  logic srst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge ck)
        r_sync <= !srst_n ? '0 : {r_sync[STAGES-2:0], i_d};
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/te_radio_enable_seq.sv
// te_radio_enable_seq: sequences an async radio request into a warmed-up, minimum-on, cooled-down enable
//   ck clock, srst_n synchronous active-low reset, bus request/isolate in, enable/busy/warmup_done out
module te_radio_enable_seq
    import te_radio_enable_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = TE_SYNC_STAGES,
    parameter int WARMUP_CYC   = TE_WARMUP_CYC,
    parameter int MIN_ON_CYC   = TE_MIN_ON_CYC,
    parameter int COOLDOWN_CYC = TE_COOLDOWN_CYC
) (
    input logic ck,
    input logic srst_n,
    te_radio_enable_seq_if.slave bus
);
    localparam int CNT_W = cnt_width(WARMUP_CYC, MIN_ON_CYC, COOLDOWN_CYC);
    if (SYNC_STAGES < 2 || WARMUP_CYC < 1 || MIN_ON_CYC < 1 || COOLDOWN_CYC < 1) begin : g_bad_param
        $error("te_radio_enable_seq: illegal timing parameters");
    end
    te_re_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_warmup_done, w_warmup_done_nxt;
    logic             w_req_s, w_cnt_zero;
    te_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .ck     (ck),
        .srst_n (srst_n),
        .i_d    (bus.radio_req_async),
        .o_q    (w_req_s)
    );
    assign w_cnt_zero = r_cnt == '0;
    always_ff @(posedge ck) begin
        if (!srst_n) begin
            r_state       <= TE_RE_IDLE;
            r_cnt         <= '0;
            r_warmup_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_warmup_done <= w_warmup_done_nxt;
        end
    end
    // Counter is only loaded on entry and only decremented while nonzero, so it never wraps.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_warmup_done_nxt = 1'b0;
        if (bus.isolateM1M2) begin
            w_state_nxt = TE_RE_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                TE_RE_IDLE: if (w_req_s) begin
                    w_state_nxt = TE_RE_WARMUP;
                    w_cnt_nxt   = CNT_W'(WARMUP_CYC - 1);
                end
                TE_RE_WARMUP: if (!w_req_s) begin
                    w_state_nxt = TE_RE_COOLDOWN;
                    w_cnt_nxt   = CNT_W'(COOLDOWN_CYC - 1);
                end else if (w_cnt_zero) begin
                    w_state_nxt       = TE_RE_ON;
                    w_cnt_nxt         = CNT_W'(MIN_ON_CYC - 1);
                    w_warmup_done_nxt = 1'b1;
                end else w_cnt_nxt = r_cnt - 1'b1;
                TE_RE_ON: if (!w_cnt_zero) w_cnt_nxt = r_cnt - 1'b1;
                else if (!w_req_s) begin
                    w_state_nxt = TE_RE_COOLDOWN;
                    w_cnt_nxt   = CNT_W'(COOLDOWN_CYC - 1);
                end
                default: if (w_cnt_zero) w_state_nxt = TE_RE_IDLE;
                else w_cnt_nxt = r_cnt - 1'b1;
            endcase
        end
    end
    // Plain gate on the state flop so isolation clamps the enable within the same cycle.
    assign bus.radioEnableSynced = (r_state == TE_RE_ON) & ~bus.isolateM1M2;
    assign bus.radio_busy        = r_state != TE_RE_IDLE;
    assign bus.warmup_done       = r_warmup_done;
endmodule
